// File: rtl/cache_flush_controller_pkg.sv
// Shared cache-system types for the flush controller and its clients.
package CacheSystemTypes;

  // Upper bound on the number of flush clients one controller can serve.
  localparam int unsigned FLUSH_CHANNEL_NUM_MAX = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMPLETE = 2'd2
  } FlushCtrlState;

  typedef logic [FLUSH_CHANNEL_NUM_MAX-1:0] FlushChannelVec;

endpackage

// File: rtl/cache_flush_controller_picker.sv
// Combinational lowest-set-bit picker; output is one-hot or all zero.
module flush_priority_picker #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] reqVec,
  output logic [WIDTH-1:0] grantVec
);

  // Two's-complement trick: x & -x keeps only the lowest set bit.
  assign grantVec = reqVec & (~reqVec + WIDTH'(1));

endmodule

// File: rtl/cache_flush_controller.sv
// Multi-channel cache flush coordinator with ordered/parallel modes and a
// no-progress timeout. flushStartAck is the only combinational output.
module cache_flush_controller
  import CacheSystemTypes::*;
#(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned ORDERED        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flushStart,
  input  logic [NUM_CHANNELS-1:0] flushMask,
  output logic                    flushStartAck,
  output logic                    flushBusy,
  output logic [NUM_CHANNELS-1:0] flushReq,
  input  logic [NUM_CHANNELS-1:0] flushReqAck,
  input  logic [NUM_CHANNELS-1:0] flushDone,
  output logic                    flushComplete,
  output logic                    flushTimedOut
);

  localparam int unsigned CntW        = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned TimeoutLast = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

  FlushCtrlState           state;
  logic [NUM_CHANNELS-1:0] remaining;
  logic [NUM_CHANNELS-1:0] acked;
  logic [CntW-1:0]         toCnt;

  logic [NUM_CHANNELS-1:0] pickNow;
  logic [NUM_CHANNELS-1:0] pickNext;
  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] eligNext;
  logic [NUM_CHANNELS-1:0] ackAcc;
  logic [NUM_CHANNELS-1:0] doneAcc;
  logic [NUM_CHANNELS-1:0] remNext;
  logic [NUM_CHANNELS-1:0] ackedNext;
  logic [NUM_CHANNELS-1:0] reqNext;
  logic                    progress;
  logic                    timeoutHit;

  flush_priority_picker #(.WIDTH(NUM_CHANNELS)) pickNowI (
    .reqVec   (remaining),
    .grantVec (pickNow)
  );

  flush_priority_picker #(.WIDTH(NUM_CHANNELS)) pickNextI (
    .reqVec   (remNext),
    .grantVec (pickNext)
  );

  // Acceptance is decided in IDLE from the live request so the ack lands in the same cycle.
  assign flushStartAck = (state == IDLE) && flushStart && !rst;

  // Handshake qualification and next-cycle channel bookkeeping.
  always_comb begin
    eligible   = (ORDERED != 0) ? pickNow : remaining;
    ackAcc     = '0;
    doneAcc    = '0;
    remNext    = remaining;
    ackedNext  = acked;
    if (state == ACTIVE) begin
      ackAcc    = flushReq & flushReqAck;
      doneAcc   = eligible & (acked | ackAcc) & flushDone;
      remNext   = remaining & ~doneAcc;
      ackedNext = acked | ackAcc;
    end else if (state == IDLE) begin
      remNext   = flushMask;
      ackedNext = '0;
    end
    eligNext   = (ORDERED != 0) ? pickNext : remNext;
    reqNext    = eligNext & ~ackedNext;
    progress   = (ackAcc != '0) || (doneAcc != '0);
    timeoutHit = (TIMEOUT_CYCLES != 0) && !progress && (toCnt == CntW'(TimeoutLast));
  end

  // Flush sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      remaining     <= '0;
      acked         <= '0;
      toCnt         <= '0;
      flushBusy     <= 1'b0;
      flushReq      <= '0;
      flushComplete <= 1'b0;
      flushTimedOut <= 1'b0;
    end else begin
      flushComplete <= 1'b0;
      case (state)
        IDLE: begin
          flushReq  <= '0;
          flushBusy <= 1'b0;
          if (flushStart) begin
            remaining     <= remNext;
            acked         <= '0;
            toCnt         <= '0;
            flushTimedOut <= 1'b0;
            flushBusy     <= 1'b1;
            if (flushMask == '0) begin
              state         <= COMPLETE;
              flushComplete <= 1'b1;
            end else begin
              state    <= ACTIVE;
              flushReq <= reqNext;
            end
          end
        end
        ACTIVE: begin
          remaining <= remNext;
          acked     <= ackedNext;
          if (progress) begin
            toCnt <= '0;
          end else if (toCnt != CntMax) begin
            toCnt <= toCnt + CntW'(1);
          end
          if (timeoutHit) begin
            state         <= COMPLETE;
            flushComplete <= 1'b1;
            flushTimedOut <= 1'b1;
            flushReq      <= '0;
          end else if (remNext == '0) begin
            state         <= COMPLETE;
            flushComplete <= 1'b1;
            flushReq      <= '0;
          end else begin
            flushReq <= reqNext;
          end
        end
        COMPLETE: begin
          state     <= IDLE;
          flushBusy <= 1'b0;
          flushReq  <= '0;
        end
        default: begin
          state     <= IDLE;
          flushBusy <= 1'b0;
          flushReq  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_flush_controller.sv
// Directed bench: dutA is parallel (N=2, timeout 8), dutB is ordered (N=3).
module tb_cache_flush_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nCompared   = 0;
  int nMismatched = 0;

  // dutA: parallel, two channels, short timeout
  logic       rstA, startA, startAckA, busyA, compA, toA;
  logic [1:0] maskA, reqA, reqAckA, doneA;
  // dutB: ordered, three channels, default timeout
  logic       rstB, startB, startAckB, busyB, compB, toB;
  logic [2:0] maskB, reqB, reqAckB, doneB;

  cache_flush_controller #(.NUM_CHANNELS(2), .ORDERED(0), .TIMEOUT_CYCLES(8)) dutA (
    .clk(clk), .rst(rstA), .flushStart(startA), .flushMask(maskA),
    .flushStartAck(startAckA), .flushBusy(busyA), .flushReq(reqA),
    .flushReqAck(reqAckA), .flushDone(doneA), .flushComplete(compA),
    .flushTimedOut(toA)
  );

  cache_flush_controller #(.NUM_CHANNELS(3), .ORDERED(1), .TIMEOUT_CYCLES(1024)) dutB (
    .clk(clk), .rst(rstB), .flushStart(startB), .flushMask(maskB),
    .flushStartAck(startAckB), .flushBusy(busyB), .flushReq(reqB),
    .flushReqAck(reqAckB), .flushDone(doneB), .flushComplete(compB),
    .flushTimedOut(toB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int ackCnt;

  initial begin
    rstA = 1'b1; startA = 1'b0; maskA = '0; reqAckA = '0; doneA = '0;
    rstB = 1'b1; startB = 1'b0; maskB = '0; reqAckB = '0; doneB = '0;
    step(); step();
    rstA = 1'b0; rstB = 1'b0;
    #1;
    checkVal("rst_busyA", 32'(busyA), 0);
    checkVal("rst_reqA", 32'(reqA), 0);
    checkVal("rst_compA", 32'(compA), 0);
    checkVal("rst_toA", 32'(toA), 0);
    checkVal("rst_startAckA", 32'(startAckA), 0);
    checkVal("rst_reqB", 32'(reqB), 0);
    checkVal("rst_busyB", 32'(busyB), 0);
    step();

    // Parallel flush, both channels, staggered dones.
    startA = 1'b1; maskA = 2'b11; #1;
    checkVal("par_startAck", 32'(startAckA), 1);
    checkVal("par_busyT", 32'(busyA), 0);
    step();
    startA = 1'b0; reqAckA = 2'b11; #1;
    checkVal("par_reqT1", 32'(reqA), 2'b11);
    checkVal("par_busyT1", 32'(busyA), 1);
    step();
    reqAckA = 2'b00; #1;
    checkVal("par_reqT2", 32'(reqA), 0);
    step();
    doneA = 2'b01; #1;
    checkVal("par_compT3", 32'(compA), 0);
    step();
    doneA = 2'b00; #1;
    checkVal("par_compT4", 32'(compA), 0);
    step();
    doneA = 2'b10; #1;
    checkVal("par_compT5", 32'(compA), 0);
    step();
    doneA = 2'b00; #1;
    checkVal("par_compT6", 32'(compA), 1);
    checkVal("par_toT6", 32'(toA), 0);
    checkVal("par_busyT6", 32'(busyA), 1);
    checkVal("par_reqT6", 32'(reqA), 0);
    step();
    #1;
    checkVal("par_compT7", 32'(compA), 0);
    checkVal("par_busyT7", 32'(busyA), 0);

    // Empty mask completes immediately.
    startA = 1'b1; maskA = 2'b00; #1;
    checkVal("zero_startAck", 32'(startAckA), 1);
    step();
    startA = 1'b0; #1;
    checkVal("zero_comp", 32'(compA), 1);
    checkVal("zero_req", 32'(reqA), 0);
    step();
    #1;
    checkVal("zero_compAfter", 32'(compA), 0);
    checkVal("zero_busyAfter", 32'(busyA), 0);

    // Timeout: channel 0 acks but never signals done.
    startA = 1'b1; maskA = 2'b01; #1;
    step();
    startA = 1'b0; reqAckA = 2'b01; #1;
    checkVal("to_reqT1", 32'(reqA), 2'b01);
    step();
    reqAckA = 2'b00;
    for (int k = 2; k <= 9; k++) begin
      #1;
      checkVal("to_waitComp", 32'(compA), 0);
      checkVal("to_waitFlag", 32'(toA), 0);
      checkVal("to_waitReq", 32'(reqA), 0);
      step();
    end
    #1;
    checkVal("to_comp", 32'(compA), 1);
    checkVal("to_flag", 32'(toA), 1);
    checkVal("to_req", 32'(reqA), 0);
    step();
    #1;
    checkVal("to_sticky", 32'(toA), 1);
    checkVal("to_compOnce", 32'(compA), 0);
    startA = 1'b1; maskA = 2'b00; #1;
    checkVal("to_reaccept", 32'(startAckA), 1);
    step();
    startA = 1'b0; #1;
    checkVal("to_cleared", 32'(toA), 0);
    checkVal("to_zeroComp", 32'(compA), 1);
    step();

    // Reset in the middle of an active flush.
    startA = 1'b1; maskA = 2'b11; #1;
    step();
    startA = 1'b0; #1;
    checkVal("mid_reqBefore", 32'(reqA), 2'b11);
    rstA = 1'b1;
    step();
    rstA = 1'b0; #1;
    checkVal("mid_req", 32'(reqA), 0);
    checkVal("mid_busy", 32'(busyA), 0);
    checkVal("mid_comp", 32'(compA), 0);
    checkVal("mid_to", 32'(toA), 0);
    step();
    #1;
    checkVal("mid_noComp", 32'(compA), 0);
    checkVal("mid_idleBusy", 32'(busyA), 0);
    startA = 1'b1; maskA = 2'b01; #1;
    checkVal("mid_reaccept", 32'(startAckA), 1);
    step();
    startA = 1'b0; reqAckA = 2'b01; #1;
    checkVal("mid_freshReq", 32'(reqA), 2'b01);
    step();
    reqAckA = 2'b00; doneA = 2'b01; #1;
    step();
    doneA = 2'b00; #1;
    checkVal("mid_freshComp", 32'(compA), 1);
    step();
    #1;
    checkVal("mid_freshIdle", 32'(busyA), 0);

    // Ordered flush, mask 101: channel 0 then channel 2, never channel 1.
    startB = 1'b1; maskB = 3'b101; #1;
    checkVal("ord_startAck", 32'(startAckB), 1);
    step();
    startB = 1'b0; #1;
    checkVal("ord_reqT1", 32'(reqB), 3'b001);
    step();
    reqAckB = 3'b001; #1;
    checkVal("ord_reqT2", 32'(reqB), 3'b001);
    step();
    reqAckB = 3'b000; #1;
    checkVal("ord_reqT3", 32'(reqB), 3'b000);
    step();
    doneB = 3'b001; #1;
    checkVal("ord_reqT4", 32'(reqB), 3'b000);
    step();
    doneB = 3'b000; #1;
    checkVal("ord_reqT5", 32'(reqB), 3'b100);
    step();
    reqAckB = 3'b100; #1;
    checkVal("ord_reqT6", 32'(reqB), 3'b100);
    step();
    reqAckB = 3'b000; #1;
    checkVal("ord_reqT7", 32'(reqB), 3'b000);
    step();
    doneB = 3'b100; #1;
    checkVal("ord_compT8", 32'(compB), 0);
    step();
    doneB = 3'b000; #1;
    checkVal("ord_compT9", 32'(compB), 1);
    checkVal("ord_reqT9", 32'(reqB), 0);
    step();
    #1;
    checkVal("ord_compT10", 32'(compB), 0);
    checkVal("ord_busyT10", 32'(busyB), 0);

    // flushStart held for 20 cycles; early done and stray ack are ignored.
    ackCnt = 0;
    startB = 1'b1; maskB = 3'b011;
    for (int c = 0; c < 20; c++) begin
      reqAckB = 3'b000; doneB = 3'b000;
      case (c)
        1: begin doneB = 3'b001; reqAckB = 3'b010; end
        2: reqAckB = 3'b001;
        3: doneB = 3'b001;
        4: reqAckB = 3'b010;
        5: doneB = 3'b010;
        default: ;
      endcase
      #1;
      ackCnt += int'(startAckB);
      case (c)
        1: checkVal("hold_reqC1", 32'(reqB), 3'b001);
        2: checkVal("hold_reqC2", 32'(reqB), 3'b001);
        3: checkVal("hold_reqC3", 32'(reqB), 3'b000);
        4: checkVal("hold_reqC4", 32'(reqB), 3'b010);
        5: checkVal("hold_reqC5", 32'(reqB), 3'b000);
        6: checkVal("hold_compC6", 32'(compB), 1);
        7: checkVal("hold_reackC7", 32'(startAckB), 1);
        8: checkVal("hold_reqC8", 32'(reqB), 3'b001);
        default: ;
      endcase
      step();
    end
    startB = 1'b0; reqAckB = 3'b000; doneB = 3'b000;
    checkVal("hold_ackCount", 32'(ackCnt), 2);
    rstB = 1'b1;
    step();
    rstB = 1'b0; #1;
    checkVal("hold_rstReq", 32'(reqB), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
